// File: rtl/vga_pkg.sv
// Shared VGA geometry defaults and the sprite sequencer state encoding.
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned VGA_X_MAX   = 639;
  localparam int unsigned VGA_Y_MAX   = 479;
  localparam int unsigned VGA_SQ_SIZE = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MOVE,
    ST_WRITE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/sprite_move_unit.sv
// One-axis move/bounce step: advances pos by vel in dir and reflects at 0 / lim.
module sprite_move_unit
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] i_pos,
  input  logic               i_dir,
  input  logic [COORD_W-1:0] i_lim,
  input  logic [3:0]         i_vel,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_dir
);

  logic [COORD_W:0] w_sum;

  assign w_sum = {1'b0, i_pos} + {{(COORD_W-3){1'b0}}, i_vel};

  // Clamp to the border and flip direction when the step would cross it.
  always_comb begin
    o_pos = i_pos;
    o_dir = i_dir;
    if (i_dir) begin
      if (w_sum > {1'b0, i_lim}) begin
        o_pos = i_lim;
        o_dir = 1'b0;
      end else begin
        o_pos = w_sum[COORD_W-1:0];
      end
    end else begin
      if (i_pos < {{(COORD_W-4){1'b0}}, i_vel}) begin
        o_pos = '0;
        o_dir = 1'b1;
      end else begin
        o_pos = i_pos - {{(COORD_W-4){1'b0}}, i_vel};
      end
    end
  end

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Frame-rate sweep over the sprite register file using one shared move unit per axis.
module sprite_motion_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned N_SPRITES   = 4,
  parameter int unsigned X_MAX       = VGA_X_MAX,
  parameter int unsigned Y_MAX       = VGA_Y_MAX,
  parameter int unsigned SQ_SIZE     = VGA_SQ_SIZE,
  parameter int unsigned SQ_VELOCITY = 1,
  parameter int unsigned TICK_LINE   = 481
)(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [9:0]         i_x,
  input  logic [9:0]         i_y,
  input  logic               i_enable,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [2:0]         i_cfg_id,
  input  logic [9:0]         i_cfg_x,
  input  logic [9:0]         i_cfg_y,
  input  logic               i_cfg_dx,
  input  logic               i_cfg_dy,
  input  logic [2:0]         i_rd_id,
  output logic [9:0]         o_rd_x,
  output logic [9:0]         o_rd_y,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overrun,
  output logic [15:0]        o_frame_count
);

  localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX - SQ_SIZE + 1);
  localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX - SQ_SIZE + 1);
  localparam logic [3:0]         VEL      = 4'(SQ_VELOCITY);
  localparam logic [3:0]         N_ID     = 4'(N_SPRITES);
  localparam logic [2:0]         LAST_IDX = 3'(N_SPRITES - 1);

  seq_state_t r_state, w_state_nxt;

  logic [COORD_W-1:0] r_x [0:7];
  logic [COORD_W-1:0] r_y [0:7];
  logic [7:0]         r_dx, r_dy;

  logic [COORD_W-1:0] r_wx, r_wy;
  logic               r_wdx, r_wdy;
  logic [COORD_W-1:0] w_nx, w_ny;
  logic               w_ndx, w_ndy;

  logic [2:0]  r_idx;
  logic        r_cond_q, r_overrun;
  logic [15:0] r_frame_count;
  logic        w_cond, w_tick, w_start, w_last;
  logic        w_ready, w_busy, w_done, w_latch, w_move, w_commit;
  logic        w_cfg_wr, w_rd_ok;

  assign w_cond   = (i_y == 10'(TICK_LINE)) && (i_x == '0);
  assign w_tick   = w_cond && !r_cond_q;
  assign w_start  = w_tick && i_enable;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_cfg_wr = i_cfg_valid && w_ready && ({1'b0, i_cfg_id} < N_ID);
  assign w_rd_ok  = ({1'b0, i_rd_id} < N_ID);

  sprite_move_unit u_move_x (
    .i_pos (r_wx),
    .i_dir (r_wdx),
    .i_lim (X_LIM),
    .i_vel (VEL),
    .o_pos (w_nx),
    .o_dir (w_ndx)
  );

  sprite_move_unit u_move_y (
    .i_pos (r_wy),
    .i_dir (r_wdy),
    .i_lim (Y_LIM),
    .i_vel (VEL),
    .o_pos (w_ny),
    .o_dir (w_ndy)
  );

  // Sweep state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    w_move      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !w_start;
        if (w_start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_busy      = 1'b1;
        w_latch     = 1'b1;
        w_state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        w_busy      = 1'b1;
        w_move      = 1'b1;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_busy      = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = w_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tick edge memory, sweep index, frame counter and sticky overrun.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cond_q      <= 1'b0;
      r_idx         <= '0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_cond_q <= w_cond;
      if (w_start && r_state == ST_IDLE) r_idx <= '0;
      else if (w_commit && !w_last)      r_idx <= r_idx + 3'd1;
      if (w_done) r_frame_count <= r_frame_count + 16'd1;
      if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
    end
  end

  // Work registers: latch the entry in READ, hold the moved result in MOVE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wx  <= '0;
      r_wy  <= '0;
      r_wdx <= 1'b0;
      r_wdy <= 1'b0;
    end else if (w_latch) begin
      r_wx  <= r_x[r_idx];
      r_wy  <= r_y[r_idx];
      r_wdx <= r_dx[r_idx];
      r_wdy <= r_dy[r_idx];
    end else if (w_move) begin
      r_wx  <= w_nx;
      r_wy  <= w_ny;
      r_wdx <= w_ndx;
      r_wdy <= w_ndy;
    end
  end

  // Committed register file; sweep commits and config writes never coincide
  // because config is only ready in IDLE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned k = 0; k < 8; k++) begin
        r_x[k] <= COORD_W'(80 * k);
        r_y[k] <= COORD_W'(48 * k);
      end
      r_dx <= '1;
      r_dy <= '1;
    end else if (w_commit) begin
      r_x[r_idx]  <= r_wx;
      r_y[r_idx]  <= r_wy;
      r_dx[r_idx] <= r_wdx;
      r_dy[r_idx] <= r_wdy;
    end else if (w_cfg_wr) begin
      r_x[i_cfg_id]  <= i_cfg_x;
      r_y[i_cfg_id]  <= i_cfg_y;
      r_dx[i_cfg_id] <= i_cfg_dx;
      r_dy[i_cfg_id] <= i_cfg_dy;
    end
  end

  assign o_rd_x        = w_rd_ok ? r_x[i_rd_id] : '0;
  assign o_rd_y        = w_rd_ok ? r_y[i_rd_id] : '0;
  assign o_cfg_ready   = w_ready;
  assign o_busy        = w_busy;
  assign o_frame_done  = w_done;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Randomized bench for sprite_motion_sequencer against a frame-level sprite model.
module tb_sprite_motion_sequencer;

  localparam int N  = 4;
  localparam int V  = 1;
  localparam int XL = 639 - 64 + 1;
  localparam int YL = 479 - 64 + 1;
  localparam int TL = 481;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [9:0]  i_x = '0, i_y = '0;
  logic        i_enable = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [2:0]  i_cfg_id = '0;
  logic [9:0]  i_cfg_x = '0, i_cfg_y = '0;
  logic        i_cfg_dx = 1'b0, i_cfg_dy = 1'b0;
  logic [2:0]  i_rd_id = '0;
  logic [9:0]  o_rd_x, o_rd_y;
  logic        o_busy, o_frame_done, o_overrun;
  logic [15:0] o_frame_count;

  always #10 i_clk = ~i_clk;

  sprite_motion_sequencer #(
    .N_SPRITES   (N),
    .X_MAX       (639),
    .Y_MAX       (479),
    .SQ_SIZE     (64),
    .SQ_VELOCITY (V),
    .TICK_LINE   (TL)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_enable      (i_enable),
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_id      (i_cfg_id),
    .i_cfg_x       (i_cfg_x),
    .i_cfg_y       (i_cfg_y),
    .i_cfg_dx      (i_cfg_dx),
    .i_cfg_dy      (i_cfg_dy),
    .i_rd_id       (i_rd_id),
    .o_rd_x        (o_rd_x),
    .o_rd_y        (o_rd_y),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_overrun     (o_overrun),
    .o_frame_count (o_frame_count)
  );

  int checks = 0;
  int failures = 0;

  int mx [N];
  int my [N];
  int mdx[N];
  int mdy[N];
  int m_count;
  int m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = 80 * k; my[k] = 48 * k; mdx[k] = 1; mdy[k] = 1;
    end
    m_count = 0;
    m_ovr   = 0;
  endfunction

  function automatic int step_pos(input int p, input int d, input int lim);
    if (d != 0) return (p + V > lim) ? lim : p + V;
    return (p < V) ? 0 : p - V;
  endfunction

  function automatic int step_dir(input int p, input int d, input int lim);
    if (d != 0) return (p + V > lim) ? 0 : 1;
    return (p < V) ? 1 : 0;
  endfunction

  function automatic void model_frame();
    int nx, ny;
    for (int k = 0; k < N; k++) begin
      nx = step_pos(mx[k], mdx[k], XL);
      ny = step_pos(my[k], mdy[k], YL);
      mdx[k] = step_dir(mx[k], mdx[k], XL);
      mdy[k] = step_dir(my[k], mdy[k], YL);
      mx[k] = nx;
      my[k] = ny;
    end
    m_count = (m_count + 1) % 65536;
  endfunction

  // Called right after a negedge; each probe takes 1 time unit, well before the next posedge.
  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      i_rd_id = 3'(k);
      #1;
      check_eq($sformatf("%s_x%0d", tag, k), 32'(o_rd_x), (k < N) ? mx[k] : 0);
      check_eq($sformatf("%s_y%0d", tag, k), 32'(o_rd_y), (k < N) ? my[k] : 0);
    end
  endtask

  task automatic check_sprite0(input string tag, input int ex, input int ey);
    i_rd_id = 3'd0;
    #1;
    check_eq({tag, "_x"}, 32'(o_rd_x), ex);
    check_eq({tag, "_y"}, 32'(o_rd_y), ey);
  endtask

  task automatic do_cfg(input int id, input int x, input int y, input int dx, input int dy);
    @(posedge i_clk); #1;
    i_cfg_valid = 1'b1;
    i_cfg_id = 3'(id); i_cfg_x = 10'(x); i_cfg_y = 10'(y);
    i_cfg_dx = 1'(dx); i_cfg_dy = 1'(dy);
    @(negedge i_clk);
    check_eq("cfg_ready", 32'(o_cfg_ready), 1);
    @(posedge i_clk); #1;
    i_cfg_valid = 1'b0;
    if (id < N) begin
      mx[id] = x; my[id] = y; mdx[id] = dx; mdy[id] = dy;
    end
    i_rd_id = 3'(id);
    @(negedge i_clk);
    check_eq("cfg_rd_x", 32'(o_rd_x), (id < N) ? mx[id] : 0);
    check_eq("cfg_rd_y", 32'(o_rd_y), (id < N) ? my[id] : 0);
  endtask

  // Raise the tick condition at cycle 0 and hold it until cycle hold-1.
  // Optional: re-raise it for one cycle at retick_at, pulse a config write at cfg_at,
  // drop i_enable at en_off_at. A negative value disables the option.
  task automatic run_sweep(input int en, input int hold, input int retick_at,
                           input int cfg_at, input int en_off_at);
    int done_at, pulses, busy_cnt;
    @(posedge i_clk); #1;
    i_enable = 1'(en);
    i_x = '0;
    i_y = 10'(TL);
    if (cfg_at == 0) begin
      i_cfg_valid = 1'b1; i_cfg_id = 3'd0; i_cfg_x = 10'd7; i_cfg_y = 10'd9;
      i_cfg_dx = 1'b0; i_cfg_dy = 1'b0;
    end
    @(negedge i_clk);
    check_eq("tick_ready", 32'(o_cfg_ready), (en != 0) ? 0 : 1);
    done_at = -1; pulses = 0; busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk); #1;
      i_y = ((c < hold) || (c == retick_at)) ? 10'(TL) : 10'd0;
      if (c == cfg_at) begin
        i_cfg_valid = 1'b1; i_cfg_id = 3'd0; i_cfg_x = 10'd7; i_cfg_y = 10'd9;
        i_cfg_dx = 1'b0; i_cfg_dy = 1'b0;
      end else begin
        i_cfg_valid = 1'b0;
      end
      if (c == en_off_at) i_enable = 1'b0;
      @(negedge i_clk);
      if (c == cfg_at) check_eq("busy_ready", 32'(o_cfg_ready), 0);
      if (o_frame_done) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      if (o_busy) busy_cnt++;
    end
    if (en != 0) model_frame();
    if (retick_at > 0) m_ovr = 1;
    check_eq("done_pulses", pulses, (en != 0) ? 1 : 0);
    check_eq("done_at", done_at, (en != 0) ? 3 * N + 1 : -1);
    check_eq("busy_cycles", busy_cnt, (en != 0) ? 3 * N + 1 : 0);
    check_eq("frame_count", 32'(o_frame_count), m_count);
    check_eq("overrun", 32'(o_overrun), m_ovr);
    check_all("frame");
  endtask

  initial begin
    int seen;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_done", 32'(o_frame_done), 0);
    check_eq("rst_ovr", 32'(o_overrun), 0);
    check_eq("rst_count", 32'(o_frame_count), 0);
    check_eq("rst_ready", 32'(o_cfg_ready), 1);
    check_all("rst");

    run_sweep(1, 1, -1, -1, -1);
    check_sprite0("first", 1, 1);

    do_cfg(0, XL, YL, 1, 1);
    run_sweep(1, 1, -1, -1, -1);
    check_sprite0("rb_hit", 576, 416);
    run_sweep(1, 1, -1, -1, -1);
    check_sprite0("rb_back", 575, 415);

    do_cfg(0, 0, 0, 0, 0);
    run_sweep(1, 1, -1, -1, -1);
    check_sprite0("lt_hit", 0, 0);
    run_sweep(1, 1, -1, -1, -1);
    check_sprite0("lt_back", 1, 1);

    run_sweep(1, 20, -1, -1, -1);
    run_sweep(1, 1, -1, 0, -1);
    do_cfg(0, 7, 9, 0, 0);
    run_sweep(1, 1, 4, 6, -1);
    run_sweep(1, 1, -1, -1, 2);
    run_sweep(0, 1, -1, -1, -1);

    for (int it = 0; it < 8; it++) begin
      repeat (3) do_cfg($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1), $urandom_range(0, 1));
      run_sweep(($urandom_range(0, 4) != 0) ? 1 : 0, $urandom_range(1, 20), -1, -1, -1);
    end

    // Asynchronous reset five cycles into a sweep.
    @(posedge i_clk); #1;
    i_enable = 1'b1;
    i_y = 10'(TL);
    for (int c = 1; c <= 5; c++) begin
      @(posedge i_clk); #1;
      if (c == 1) i_y = '0;
    end
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_busy", 32'(o_busy), 0);
    check_eq("arst_done", 32'(o_frame_done), 0);
    check_eq("arst_ovr", 32'(o_overrun), 0);
    check_eq("arst_count", 32'(o_frame_count), 0);
    check_all("arst");
    seen = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_frame_done) seen = 1;
    end
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      if (o_frame_done) seen = 1;
    end
    check_eq("arst_no_done", seen, 0);
    check_eq("arst_idle", 32'(o_busy), 0);
    check_all("post_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
